// File: rtl/receptor_serial_pkg.sv
// rtl/receptor_serial_pkg.sv - shared states, bit-timing helpers and parity for the serial link
package receptor_serial_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} estadoT;

    function automatic int mitadBit(input int clksPorBit);
        return clksPorBit / 2;
    endfunction

    function automatic int anchoCnt(input int clksPorBit);
        return $clog2(clksPorBit);
    endfunction

    // Parity bit a transmitter sends for this word; the receiver compares against it.
    function automatic logic bitParidad(input logic [15:0] dato, input logic impar);
        return (^dato) ^ impar;
    endfunction

endpackage

// File: rtl/receptor_serial_sincronizador.sv
// rtl/receptor_serial_sincronizador.sv - two-flop synchronizer that resets to 1 (idle line level)
module receptor_serial_sincronizador (
    input  logic iClk,
    input  logic iRst,
    input  logic iAsync,
    output logic oSync
);

    logic meta;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            meta  <= 1'b1;
            oSync <= 1'b1;
        end else begin
            meta  <= iAsync;
            oSync <= meta;
        end
    end

endmodule

// File: rtl/receptor_serial.sv
// rtl/receptor_serial.sv - framed serial receiver with valid/ack handshake and error flags
module receptor_serial
    import receptor_serial_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iRx,
    input  logic                 iAck,
    output logic [DATA_BITS-1:0] oDato,
    output logic                 oValido,
    output logic                 oErrorParidad,
    output logic                 oErrorTrama,
    output logic                 oSobrecarga,
    output logic                 oOcupado
);

    localparam int HALF_BIT = mitadBit(CLKS_PER_BIT);
    localparam int CNT_W    = anchoCnt(CLKS_PER_BIT);
    localparam int IDX_W    = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_FIN   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MEDIO = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_ULT   = IDX_W'(DATA_BITS - 1);
    localparam logic             PAR_IMPAR = (PARITY_ODD != 0);

    estadoT               estado;
    estadoT               estadoSig;
    logic                 rxS;
    logic                 rxPrev;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bitIdx;
    logic [DATA_BITS-1:0] sr;
    logic                 errPar;
    logic                 finBit;
    logic                 finMedio;
    logic                 muestraDato;
    logic                 muestraPar;
    logic                 completo;
    logic                 reinicioCnt;

    receptor_serial_sincronizador uSinc (
        .iClk   (iClk),
        .iRst   (iRst),
        .iAsync (iRx),
        .oSync  (rxS)
    );

    assign finBit   = (cnt == CNT_FIN);
    assign finMedio = (cnt == CNT_MEDIO);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            estado <= IDLE;
        end else begin
            estado <= estadoSig;
        end
    end

    always_comb begin
        estadoSig = estado;
        unique case (estado)
            IDLE:   if (rxPrev && !rxS) estadoSig = START;
            START:  if (finMedio) estadoSig = rxS ? IDLE : DATA;
            DATA:   if (finBit && bitIdx == IDX_ULT) estadoSig = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (finBit) estadoSig = STOP;
            STOP:   if (finBit) estadoSig = IDLE;
            default: estadoSig = IDLE;
        endcase
    end

    always_comb begin
        muestraDato = (estado == DATA) && finBit;
        muestraPar  = (estado == PARITY) && finBit;
        completo    = (estado == STOP) && finBit;
        // Restart the bit timer on every state change and between data bits.
        reinicioCnt = (estadoSig != estado) || muestraDato;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rxPrev <= 1'b1;
            cnt    <= '0;
            bitIdx <= '0;
            sr     <= '0;
            errPar <= 1'b0;
        end else begin
            rxPrev <= rxS;
            if (reinicioCnt) begin
                cnt <= '0;
            end else if (estado != IDLE) begin
                cnt <= cnt + 1'b1;
            end
            if (estado == START && finMedio) begin
                bitIdx <= '0;
                errPar <= 1'b0;
            end else if (muestraDato) begin
                bitIdx <= bitIdx + 1'b1;
                sr     <= DATA_BITS'({rxS, sr} >> 1);
            end
            if (muestraPar) begin
                errPar <= (rxS != bitParidad(16'(sr), PAR_IMPAR));
            end
        end
    end

    // A completing frame takes priority over an acknowledge in the same cycle.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oDato         <= '0;
            oValido       <= 1'b0;
            oErrorParidad <= 1'b0;
            oErrorTrama   <= 1'b0;
            oSobrecarga   <= 1'b0;
            oOcupado      <= 1'b0;
        end else begin
            oOcupado <= (estadoSig != IDLE);
            if (completo && (!oValido || iAck)) begin
                oDato         <= sr;
                oErrorParidad <= errPar;
                oErrorTrama   <= ~rxS;
                oValido       <= 1'b1;
                oSobrecarga   <= 1'b0;
            end else if (completo) begin
                oSobrecarga <= 1'b1;
            end else if (iAck && oValido) begin
                oValido       <= 1'b0;
                oErrorParidad <= 1'b0;
                oErrorTrama   <= 1'b0;
                oSobrecarga   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_receptor_serial.sv
// tb/tb_receptor_serial.sv - directed scoreboard bench for receptor_serial
module tb_receptor_serial;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iRx;
    logic       iAck;
    logic [7:0] oDato;
    logic       oValido;
    logic       oErrorParidad;
    logic       oErrorTrama;
    logic       oSobrecarga;
    logic       oOcupado;

    receptor_serial #(
        .DATA_BITS    (8),
        .CLKS_PER_BIT (16),
        .PARITY_EN    (1),
        .PARITY_ODD   (0)
    ) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iRx           (iRx),
        .iAck          (iAck),
        .oDato         (oDato),
        .oValido       (oValido),
        .oErrorParidad (oErrorParidad),
        .oErrorTrama   (oErrorTrama),
        .oSobrecarga   (oSobrecarga),
        .oOcupado      (oOcupado)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [7:0] dato;
        logic       ep;
        logic       et;
    } esperadoT;

    esperadoT cola[$];
    int       comparados = 0;
    int       fallos = 0;
    int       ciclo = 0;
    int       cicloSubida = 0;
    int       tStart = 0;
    logic     validoPrev = 1'b0;
    logic     vistoValido = 1'b0;

    always @(posedge iClk) ciclo++;

    always @(negedge iClk) begin
        if (oValido && !validoPrev) cicloSubida = ciclo;
        if (oValido) vistoValido = 1'b1;
        validoPrev = oValido;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        comparados++;
        assert (obs === exp) else begin
            fallos++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic enviarBit(input logic b);
        iRx = b;
        repeat (16) @(negedge iClk);
    endtask

    task automatic enviarTrama(input logic [7:0] d, input logic par, input logic stp);
        enviarBit(1'b0);
        for (int i = 0; i < 8; i++) enviarBit(d[i]);
        enviarBit(par);
        enviarBit(stp);
        iRx = 1'b1;
    endtask

    task automatic esperarValido(input string tag);
        for (int i = 0; i < 40 && !oValido; i++) @(negedge iClk);
        chequear(tag, 32'(oValido), 32'd1);
    endtask

    task automatic compararSalida(input string tag);
        esperadoT e;
        chequear({tag, "_cola"}, 32'(cola.size() > 0), 32'd1);
        if (cola.size() > 0) begin
            e = cola.pop_front();
            chequear({tag, "_dato"}, 32'(oDato), 32'(e.dato));
            chequear({tag, "_paridad"}, 32'(oErrorParidad), 32'(e.ep));
            chequear({tag, "_trama"}, 32'(oErrorTrama), 32'(e.et));
        end
    endtask

    task automatic pulsoAck();
        iAck = 1'b1;
        @(negedge iClk);
        iAck = 1'b0;
    endtask

    function automatic logic paridadPar(input logic [7:0] d);
        return ^d;
    endfunction

    initial begin
        iRst = 1'b1;
        iRx  = 1'b1;
        iAck = 1'b0;
        repeat (3) @(negedge iClk);
        chequear("rst_valido", 32'(oValido), 32'd0);
        chequear("rst_dato", 32'(oDato), 32'd0);
        chequear("rst_flags", 32'({oErrorParidad, oErrorTrama, oSobrecarga}), 32'd0);
        chequear("rst_ocupado", 32'(oOcupado), 32'd0);
        iRst = 1'b0;
        repeat (10) @(negedge iClk);

        // Clean word, latency, hold without ack, then ack.
        tStart = ciclo;
        cola.push_back('{8'hA5, 1'b0, 1'b0});
        enviarTrama(8'hA5, paridadPar(8'hA5), 1'b1);
        esperarValido("a5_valido");
        compararSalida("a5");
        chequear("a5_sobrecarga", 32'(oSobrecarga), 32'd0);
        chequear("a5_latencia", 32'((cicloSubida - tStart) <= 180 && (cicloSubida - tStart) >= 160), 32'd1);
        repeat (50) @(negedge iClk);
        chequear("a5_retenido", 32'(oValido), 32'd1);
        pulsoAck();
        chequear("a5_ack", 32'(oValido), 32'd0);

        // Wrong parity bit.
        repeat (10) @(negedge iClk);
        cola.push_back('{8'h3C, 1'b1, 1'b0});
        enviarTrama(8'h3C, ~paridadPar(8'h3C), 1'b1);
        esperarValido("3c_valido");
        compararSalida("3c");
        pulsoAck();
        chequear("3c_ack_flags", 32'({oValido, oErrorParidad}), 32'd0);

        // Stop bit low, then a clean word after the line returns high.
        repeat (10) @(negedge iClk);
        cola.push_back('{8'h0F, 1'b0, 1'b1});
        enviarTrama(8'h0F, paridadPar(8'h0F), 1'b0);
        esperarValido("0f_valido");
        compararSalida("0f");
        pulsoAck();
        repeat (20) @(negedge iClk);
        cola.push_back('{8'h81, 1'b0, 1'b0});
        enviarTrama(8'h81, paridadPar(8'h81), 1'b1);
        esperarValido("81_valido");
        compararSalida("81");
        pulsoAck();

        // Short low glitch is a false start.
        repeat (20) @(negedge iClk);
        vistoValido = 1'b0;
        iRx = 1'b0;
        repeat (4) @(negedge iClk);
        iRx = 1'b1;
        repeat (2) @(negedge iClk);
        chequear("glitch_ocupado_alto", 32'(oOcupado), 32'd1);
        repeat (10) @(negedge iClk);
        chequear("glitch_ocupado_bajo", 32'(oOcupado), 32'd0);
        repeat (200) @(negedge iClk);
        chequear("glitch_sin_valido", 32'(vistoValido), 32'd0);

        // Back-to-back without ack: second word is dropped with overrun.
        cola.push_back('{8'h11, 1'b0, 1'b0});
        enviarTrama(8'h11, paridadPar(8'h11), 1'b1);
        enviarTrama(8'h22, paridadPar(8'h22), 1'b1);
        repeat (5) @(negedge iClk);
        chequear("overrun_valido", 32'(oValido), 32'd1);
        compararSalida("11");
        chequear("overrun_flag", 32'(oSobrecarga), 32'd1);

        // Ack exactly in the completion cycle of the next word: new word wins.
        repeat (20) @(negedge iClk);
        cola.push_back('{8'h33, 1'b0, 1'b0});
        fork
            enviarTrama(8'h33, paridadPar(8'h33), 1'b1);
            begin
                repeat (170) @(negedge iClk);
                chequear("33_previo_dato", 32'(oDato), 32'h11);
                iAck = 1'b1;
                @(negedge iClk);
                iAck = 1'b0;
                chequear("33_valido", 32'(oValido), 32'd1);
                chequear("33_sobrecarga", 32'(oSobrecarga), 32'd0);
            end
        join
        compararSalida("33");
        pulsoAck();
        chequear("33_ack", 32'({oValido, oSobrecarga}), 32'd0);

        // Reset during data bit 4 aborts the frame silently.
        repeat (20) @(negedge iClk);
        vistoValido = 1'b0;
        enviarBit(1'b0);
        for (int i = 0; i < 4; i++) enviarBit(1'b1);
        iRx = 1'b0;
        repeat (8) @(negedge iClk);
        iRst = 1'b1;
        repeat (2) @(negedge iClk);
        iRx  = 1'b1;
        iRst = 1'b0;
        repeat (20) @(negedge iClk);
        chequear("abort_ocupado", 32'(oOcupado), 32'd0);
        chequear("abort_sin_valido", 32'(vistoValido), 32'd0);
        cola.push_back('{8'h5A, 1'b0, 1'b0});
        enviarTrama(8'h5A, paridadPar(8'h5A), 1'b1);
        esperarValido("5a_valido");
        compararSalida("5a");
        chequear("5a_sobrecarga", 32'(oSobrecarga), 32'd0);
        pulsoAck();

        chequear("cola_vacia", 32'(cola.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, fallos);
        $finish;
    end

endmodule
